// File: rtl/d_e_pipe_reg.sv
// d_e_pipe_reg: Decode-to-Execute pipeline register with bubble/flush and W-stage operand refresh
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall               load a bubble into E (PC_E/bd_E keep the D values)
//   req                 exception/interrupt flush, E becomes a handler bubble
//   *_D                 Decode-stage values to latch
//   w_we/w_addr/w_data  W-stage GRF write port, used to refresh operands
//   *_E                 registered Execute-stage copies (tnew_E pre-decremented)
module d_e_pipe_reg #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
    parameter int          TNEW_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req,
    input  logic [31:0]       instr_D,
    input  logic [31:0]       PC_D,
    input  logic [31:0]       rs_data_D,
    input  logic [31:0]       rt_data_D,
    input  logic [31:0]       imm_D,
    input  logic [4:0]        rs_D,
    input  logic [4:0]        rt_D,
    input  logic [4:0]        a3_D,
    input  logic [TNEW_W-1:0] tnew_D,
    input  logic              bd_D,
    input  logic [4:0]        exc_D,
    input  logic              w_we,
    input  logic [4:0]        w_addr,
    input  logic [31:0]       w_data,
    output logic [31:0]       instr_E,
    output logic [31:0]       PC_E,
    output logic [31:0]       rs_data_E,
    output logic [31:0]       rt_data_E,
    output logic [31:0]       imm_E,
    output logic [4:0]        rs_E,
    output logic [4:0]        rt_E,
    output logic [4:0]        a3_E,
    output logic [TNEW_W-1:0] tnew_E,
    output logic              bd_E,
    output logic [4:0]        exc_E
);

    logic              w_valid;
    logic              fwd_rs;
    logic              fwd_rt;
    logic [31:0]       rs_data_in;
    logic [31:0]       rt_data_in;
    logic [TNEW_W-1:0] tnew_dec;

    // A W write in the same cycle as the GRF read would be missed by the read port;
    // $0 is never refreshed.
    always_comb begin
        w_valid    = w_we && (w_addr != 5'd0);
        fwd_rs     = w_valid && (w_addr == rs_D);
        fwd_rt     = w_valid && (w_addr == rt_D);
        rs_data_in = fwd_rs ? w_data : rs_data_D;
        rt_data_in = fwd_rt ? w_data : rt_data_D;
        tnew_dec   = (tnew_D == '0) ? '0 : tnew_D - TNEW_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || req) begin
            instr_E   <= '0;
            PC_E      <= reset ? PC_RESET : PC_HANDLER;
            rs_data_E <= '0;
            rt_data_E <= '0;
            imm_E     <= '0;
            rs_E      <= '0;
            rt_E      <= '0;
            a3_E      <= '0;
            tnew_E    <= '0;
            bd_E      <= 1'b0;
            exc_E     <= '0;
        end else if (stall) begin
            // Bubble keeps PC/BD so EPC stays correct if an interrupt lands here.
            instr_E   <= '0;
            PC_E      <= PC_D;
            rs_data_E <= '0;
            rt_data_E <= '0;
            imm_E     <= '0;
            rs_E      <= '0;
            rt_E      <= '0;
            a3_E      <= '0;
            tnew_E    <= '0;
            bd_E      <= bd_D;
            exc_E     <= '0;
        end else begin
            instr_E   <= instr_D;
            PC_E      <= PC_D;
            rs_data_E <= rs_data_in;
            rt_data_E <= rt_data_in;
            imm_E     <= imm_D;
            rs_E      <= rs_D;
            rt_E      <= rt_D;
            a3_E      <= a3_D;
            tnew_E    <= tnew_dec;
            bd_E      <= bd_D;
            exc_E     <= exc_D;
        end
    end

endmodule

// File: doc/d_e_pipe_reg.md
Name: d_e_pipe_reg

Overview:
- Pipeline register between the Decode stage (GRF read, operand forwarding, instruction decode) and the Execute stage.
- Latches the two GRF read operands (after D-stage forwarding), the immediate, the register addresses, the write-back target, the hazard Tnew value and the exception context.
- Inserts bubbles on hazard stall and flushes on exception/interrupt request.
- Refreshes its held operands from the W-stage write port, so E-stage operands stay coherent with the GRF.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
PC_HANDLER, 32'h0000_4180, PC value loaded on flush (exception entry)
TNEW_W, 2, width of the Tnew field

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard-unit stall: load a bubble into E this cycle
req  in  1  exception/interrupt request: flush E to handler bubble
instr_D  in  32  D-stage instruction word
PC_D  in  32  D-stage PC
rs_data_D  in  32  forwarded rs operand (GRF Read1 path)
rt_data_D  in  32  forwarded rt operand (GRF Read2 path)
imm_D  in  32  extended immediate
rs_D  in  5  rs address
rt_D  in  5  rt address
a3_D  in  5  write-back register address (0 = no write)
tnew_D  in  TNEW_W  cycles until result is ready, counted from D
bd_D  in  1  instruction is in a branch delay slot
exc_D  in  5  exception code accumulated through D (0 = none)
w_we  in  1  W-stage GRF write enable
w_addr  in  5  W-stage GRF write address
w_data  in  32  W-stage GRF write data
instr_E, PC_E, rs_data_E, rt_data_E, imm_E  out  32  registered copies
rs_E, rt_E, a3_E  out  5  registered copies
tnew_E  out  TNEW_W  registered Tnew, already decremented
bd_E  out  1  registered delay-slot flag
exc_E  out  5  registered exception code

Behaviour:
- All outputs are registered; there is no combinational path from any input to any output. Latency is 1 cycle.
- Priority per rising edge: reset > req > stall > normal load.
- reset: every output is 0 except PC_E = PC_RESET.
- req: every output is 0 except PC_E = PC_HANDLER. The stall input is ignored in that cycle.
- stall (without req): bubble.
  - instr_E, operands, imm, addresses, tnew_E and exc_E are all 0.
  - PC_E = PC_D and bd_E = bd_D are kept, so EPC/BD stay correct if an interrupt lands on the bubble.
- Normal load: every *_E output takes its *_D input, except for tnew_E and the operand refresh rules below.
- tnew_E = tnew_D − 1, saturating at 0; tnew_D = 0 gives tnew_E = 0.
- Operand refresh on a cycle with no new load (reserved for a future hold mode; currently every non-reset cycle loads):
  - If w_we, w_addr ≠ 0 and w_addr == rs_E, then rs_data_E ← w_data.
  - The rt side follows the same rule with rt_E.
- Operand refresh on a normal-load cycle:
  - If w_we, w_addr ≠ 0 and w_addr == rs_D, then rs_data_E ← w_data instead of rs_data_D.
  - The rt side follows the same rule with rt_D.
  - This covers a W write that happens in the same cycle the GRF was read.
- Register 0: a write to address 0 never refreshes an operand; an operand addressed by $0 is always latched as rs_data_D/rt_data_D unchanged.
- a3_E is taken exactly as given. Suppressing writes to $0 is the job of the W stage, not this block.
- No internal FSM beyond the three load modes. All state is flops; the block is unaffected by X on the D inputs while reset or req is asserted.

Test Plan:
1. Assert reset for 2 cycles with arbitrary D inputs -> PC_E = 0x3000, every other output 0; on the first cycle after deassertion with PC_D = 0x3004, PC_E = 0x3004.
2. Normal load: instr_D = 0x8C430004, rs_data_D = 0x11, rt_data_D = 0x22, a3_D = 3, tnew_D = 2 -> next cycle the same values appear on the E outputs and tnew_E = 1; repeat with tnew_D = 0 -> tnew_E = 0.
3. stall = 1 with PC_D = 0x3010, bd_D = 1, exc_D = 4 -> instr_E = 0, a3_E = 0, exc_E = 0, PC_E = 0x3010, bd_E = 1.
4. stall = 1 and req = 1 together -> PC_E = 0x4180, bd_E = 0, all other outputs 0 (req wins); req and reset together -> PC_E = 0x3000.
5. Same-cycle W refresh: rs_D = 5, rs_data_D = 0xAAAA, w_we = 1, w_addr = 5, w_data = 0x1234 -> rs_data_E = 0x1234.
6. Same as 5 but w_addr = 0 with rs_D = 0 -> rs_data_E = 0xAAAA.
